// File: rtl/cam_capture.sv
// Camera capture front end: samples the 8-bit camera bus, packs byte pairs into
// RGB565 pixels and issues linear frame-buffer writes, with optional 2x2 decimation.
module cam_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CamVsync,
    input  logic              CamHsync,
    input  logic [7:0]        CamData,
    input  logic              Decim,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [15:0]       WrData,
    output logic              FrameDone,
    output logic              FrameErr,
    output logic              Locked
);

    // Counters saturate one past the active size so overlong lines/frames stay detectable.
    localparam int XW = $clog2(H_ACTIVE + 2);
    localparam int YW = $clog2(V_ACTIVE + 2);
    localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_SAT = XW'(H_ACTIVE + 1);
    localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_SAT = YW'(V_ACTIVE + 1);

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_FS,
        ACTIVE
    } state_t;

    state_t state, next_state;

    logic              vs_d, hs_d;
    logic              dec_r;
    logic              phase;
    logic              err;
    logic [7:0]        hi_r;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;

    logic vs_rise, vs_fall, hs_fall;
    logic frame_start, frame_end, store_ok;

    assign vs_rise     = CamVsync & ~vs_d;
    assign vs_fall     = ~CamVsync & vs_d;
    assign hs_fall     = ~CamHsync & hs_d;
    assign frame_start = (state == WAIT_FS) && vs_fall;
    assign frame_end   = (state == ACTIVE) && vs_rise;
    assign store_ok    = (x < X_END) && (y < Y_END) && (!dec_r || (!x[0] && !y[0]));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= WAIT_VS;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_VS: if (CamVsync)    next_state = WAIT_FS;
            WAIT_FS: if (frame_start) next_state = ACTIVE;
            ACTIVE:  if (frame_end)   next_state = WAIT_FS;
            default:                  next_state = WAIT_VS;
        endcase
    end

    // Frame end takes priority over capture, so a line cut by Vsync never writes its pending byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vs_d      <= 1'b0;
            hs_d      <= 1'b0;
            dec_r     <= 1'b0;
            phase     <= 1'b0;
            err       <= 1'b0;
            hi_r      <= 8'd0;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            WrEn      <= 1'b0;
            WrAddr    <= '0;
            WrData    <= 16'd0;
            FrameDone <= 1'b0;
            FrameErr  <= 1'b0;
            Locked    <= 1'b0;
        end else begin
            vs_d      <= CamVsync;
            hs_d      <= CamHsync;
            WrEn      <= 1'b0;
            FrameDone <= 1'b0;
            FrameErr  <= 1'b0;
            if (frame_start) begin
                Locked <= 1'b1;
                dec_r  <= Decim;
                x      <= '0;
                y      <= '0;
                addr   <= '0;
                err    <= 1'b0;
                phase  <= 1'b0;
            end else if (frame_end) begin
                if (err || CamHsync || (y != Y_END)) begin
                    FrameErr <= 1'b1;
                end else begin
                    FrameDone <= 1'b1;
                end
                phase <= 1'b0;
            end else if (state == ACTIVE) begin
                if (CamHsync) begin
                    phase <= ~phase;
                    if (!phase) begin
                        hi_r <= CamData;
                    end else begin
                        if (store_ok) begin
                            WrEn   <= 1'b1;
                            WrData <= {hi_r, CamData};
                            WrAddr <= addr;
                            addr   <= addr + ADDR_W'(1);
                        end
                        if (x != X_SAT) begin
                            x <= x + XW'(1);
                        end
                    end
                end else if (hs_fall) begin
                    if ((x != X_END) || phase) begin
                        err <= 1'b1;
                    end
                    x     <= '0;
                    phase <= 1'b0;
                    if (y != Y_SAT) begin
                        y <= y + YW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Camera capture front end; sits directly upstream of the video processing core in the camera-to-VGA path.
- Samples the 8-bit parallel camera bus (VSYNC, HREF/HSYNC, data) on the camera pixel clock.
- Assembles byte pairs into RGB565 pixels and emits frame-buffer write strobes with linear addresses.
- Optional 2x2 decimation; reports frame completion and geometry errors.

Parameters:
- H_ACTIVE, 640, pixels per line expected from the camera.
- V_ACTIVE, 480, lines per frame expected.
- ADDR_W, 19, width of the write address; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- CLK  in  1  camera pixel clock (PCLK); the only clock.
- RST  in  1  asynchronous, active-high reset.
- CamVsync  in  1  frame sync; high = vertical blanking.
- CamHsync  in  1  line valid (HREF); high = active bytes on CamData.
- CamData  in  8  camera byte bus.
- Decim  in  1  1 = 2x2 subsample to H_ACTIVE/2 x V_ACTIVE/2; sampled only at frame start.
- WrEn  out  1  frame-buffer write strobe, one cycle per stored pixel.
- WrAddr  out  ADDR_W  linear pixel address.
- WrData  out  16  RGB565 pixel, {first byte, second byte}.
- FrameDone  out  1  one-cycle pulse at the end of a clean frame.
- FrameErr  out  1  one-cycle pulse at the end of a malformed frame.
- Locked  out  1  high once the first frame start after reset has been seen.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values: all outputs 0; state WAIT_VS; counters, byte phase and error flag cleared.

State machine:
- WAIT_VS: wait for CamVsync=1, then go to WAIT_FS. No writes.
- WAIT_FS: on CamVsync 1->0 (frame start):
  - set Locked=1 (sticky until RST);
  - latch Decim into dec_r;
  - clear x, y, address and error flag;
  - go to ACTIVE.
- ACTIVE: capture pixels (below). On CamVsync 0->1 (frame end):
  - pulse FrameDone or FrameErr in that same cycle (never both);
  - go to WAIT_FS.
- Edge detection uses a one-cycle registered copy of CamVsync/CamHsync, compared against the live inputs.

Pixel capture (ACTIVE, CamHsync=1):
- Byte phase toggles every cycle, starting at 0 on the first HREF cycle.
- Phase 0: hold CamData in hi_r.
- Phase 1: form pixel {hi_r, CamData}, then increment x.
- Store condition: x < H_ACTIVE, y < V_ACTIVE, and (dec_r=0, or x[0]=0 and y[0]=0).
- When stored, WrEn/WrData/WrAddr are registered on the phase-1 edge: valid the following cycle, for exactly one cycle.
- WrAddr comes from a running counter that increments after each stored pixel. No multiplier.
- Address sequence:
  - dec_r=0: 0 .. H_ACTIVE*V_ACTIVE-1;
  - dec_r=1: 0 .. (H_ACTIVE/2)*(V_ACTIVE/2)-1.
- Pixels beyond H_ACTIVE/V_ACTIVE are dropped; x and y saturate, no wrap.

Line end (CamHsync 1->0):
- Set the error flag if x != H_ACTIVE or the byte phase is 1 (odd byte count).
- Then x=0, phase=0, y=y+1 (saturating).

Frame end:
- FrameErr if the error flag is set or y != V_ACTIVE; otherwise FrameDone.
- CamVsync rising while CamHsync=1 aborts the line: a pending hi_r is discarded, FrameErr is pulsed, and no further writes occur.

Other rules:
- CamHsync activity in WAIT_VS/WAIT_FS is ignored.
- Decim changes mid-frame have no effect until the next frame start.
- RST asserted mid-line: outputs drop to 0 immediately (async), and capture resumes only after a fresh Vsync high->low.

Test Plan:
Bench parameters: H_ACTIVE=8, V_ACTIVE=4, ADDR_W=5.
1. Reset, then Vsync high/low, 4 lines of 16 bytes with byte value = index, then Vsync high -> 32 WrEn pulses; addr 0..31; first WrData=0x0001, last=0x3E3F; FrameDone=1 for one cycle; Locked=1.
2. Same frame with Decim=1 latched at frame start -> 8 writes, addr 0..7; pixels from even x and even y only; FrameDone pulse.
3. Line 2 carries 14 bytes -> that line writes 7 pixels; FrameErr pulse at Vsync rise; FrameDone stays 0.
4. Lines of 20 bytes -> only x<8 stored per line, 32 total writes; FrameErr pulse.
5. Data before the first Vsync fall after reset -> no WrEn, Locked=0; capture begins on the next frame start.
6. RST pulsed mid-line 2 -> WrEn=0 immediately; FrameDone/FrameErr do not pulse; next full frame writes addr 0..31 cleanly.
